cr16_alu_arbiter: RTL and testbench

//   Shares one cr16_alu instance between two requesters (req0: core datapath, req1: auxiliary unit).

---
 rtl/cr16_alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cr16_alu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_alu_arbiter.sv
// cr16_alu_arbiter
//   Shares one cr16_alu between two requesters (req0: core datapath, req1:
//   auxiliary unit). A granted operation is registered onto the ALU pins, the
//   ALU enable is held for ALU_LATENCY cycles, and the ALU result is captured and
//   returned to the requester that issued it. Only one operation is in flight at a time.
// Ports
//   I_CLK, I_NRESET                         clock, async active-low reset
//   I_REQx_VALID / O_REQx_READY             request handshake (READY is combinational)
//   I_REQx_OPCODE / I_REQx_A / I_REQx_B     request payload
//   O_RSPx_VALID / I_RSPx_READY             response handshake
//   O_RSPx_C / O_RSPx_STATUS                response payload (held under backpressure)
//   O_ALU_ENABLE/OPCODE/A/B                 registered drive of the shared ALU
//   I_ALU_C / I_ALU_STATUS                  ALU result, sampled at the end of execution
module cr16_alu_arbiter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned OPCODE_WIDTH  = 4,
  parameter int unsigned STATUS_WIDTH  = 5,
  parameter int unsigned ALU_LATENCY   = 1,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic                    I_REQ0_VALID,
  output logic                    O_REQ0_READY,
  input  logic [OPCODE_WIDTH-1:0] I_REQ0_OPCODE,
  input  logic [DATA_WIDTH-1:0]   I_REQ0_A,
  input  logic [DATA_WIDTH-1:0]   I_REQ0_B,
  output logic                    O_RSP0_VALID,
  input  logic                    I_RSP0_READY,
  output logic [DATA_WIDTH-1:0]   O_RSP0_C,
  output logic [STATUS_WIDTH-1:0] O_RSP0_STATUS,
  input  logic                    I_REQ1_VALID,
  output logic                    O_REQ1_READY,
  input  logic [OPCODE_WIDTH-1:0] I_REQ1_OPCODE,
  input  logic [DATA_WIDTH-1:0]   I_REQ1_A,
  input  logic [DATA_WIDTH-1:0]   I_REQ1_B,
  output logic                    O_RSP1_VALID,
  input  logic                    I_RSP1_READY,
  output logic [DATA_WIDTH-1:0]   O_RSP1_C,
  output logic [STATUS_WIDTH-1:0] O_RSP1_STATUS,
  output logic                    O_ALU_ENABLE,
  output logic [OPCODE_WIDTH-1:0] O_ALU_OPCODE,
  output logic [DATA_WIDTH-1:0]   O_ALU_A,
  output logic [DATA_WIDTH-1:0]   O_ALU_B,
  input  logic [DATA_WIDTH-1:0]   I_ALU_C,
  input  logic [STATUS_WIDTH-1:0] I_ALU_STATUS
);

  localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               rr_q;      // 1: req1 wins the next tie
  logic               owner_q;   // requester of the operation in flight
  logic [CNT_W-1:0]   cnt_q;     // remaining EXEC cycles

  logic               grant1_c;
  logic               ready0_c;
  logic               ready1_c;
  logic               accept_c;
  logic               exec_done_c;
  logic               resp_done_c;

  // State register
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c)    state_d = S_EXEC;
      S_EXEC:  if (exec_done_c) state_d = S_RESP;
      S_RESP:  if (resp_done_c) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Grant, ready and phase strobes; ready is masked during reset
  always_comb begin
    grant1_c    = 1'b0;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    accept_c    = 1'b0;
    exec_done_c = 1'b0;
    resp_done_c = 1'b0;
    if (state_q == S_IDLE) begin
      grant1_c = I_REQ1_VALID && (!I_REQ0_VALID || ((PRIORITY_MODE == 0) && rr_q));
      ready0_c = I_NRESET && I_REQ0_VALID && !grant1_c;
      ready1_c = I_NRESET && grant1_c;
      accept_c = ready0_c || ready1_c;
    end
    exec_done_c = (state_q == S_EXEC) && (cnt_q == CNT_W'(1));
    resp_done_c = (state_q == S_RESP) && (owner_q ? I_RSP1_READY : I_RSP0_READY);
  end

  assign O_REQ0_READY = ready0_c;
  assign O_REQ1_READY = ready1_c;

  // Owner, latency counter and round-robin pointer
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept_c) begin
        owner_q <= grant1_c;
        cnt_q   <= CNT_W'(ALU_LATENCY);
      end else if (state_q == S_EXEC) begin
        cnt_q   <= cnt_q - CNT_W'(1);
      end
      if (resp_done_c) begin
        rr_q <= ~owner_q;
      end
    end
  end

  // ALU drive: operands latched on accept and held until the next accept
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_ALU_ENABLE <= 1'b0;
      O_ALU_OPCODE <= '0;
      O_ALU_A      <= '0;
      O_ALU_B      <= '0;
    end else begin
      if (accept_c) begin
        O_ALU_ENABLE <= 1'b1;
        O_ALU_OPCODE <= grant1_c ? I_REQ1_OPCODE : I_REQ0_OPCODE;
        O_ALU_A      <= grant1_c ? I_REQ1_A      : I_REQ0_A;
        O_ALU_B      <= grant1_c ? I_REQ1_B      : I_REQ0_B;
      end else if (exec_done_c) begin
        O_ALU_ENABLE <= 1'b0;
      end
    end
  end

  // Response registers: only the owner's side is written
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_RSP0_VALID  <= 1'b0;
      O_RSP0_C      <= '0;
      O_RSP0_STATUS <= '0;
      O_RSP1_VALID  <= 1'b0;
      O_RSP1_C      <= '0;
      O_RSP1_STATUS <= '0;
    end else begin
      if (exec_done_c) begin
        if (owner_q) begin
          O_RSP1_VALID  <= 1'b1;
          O_RSP1_C      <= I_ALU_C;
          O_RSP1_STATUS <= I_ALU_STATUS;
        end else begin
          O_RSP0_VALID  <= 1'b1;
          O_RSP0_C      <= I_ALU_C;
          O_RSP0_STATUS <= I_ALU_STATUS;
        end
      end
      if (resp_done_c) begin
        if (owner_q) begin
          O_RSP1_VALID <= 1'b0;
        end else begin
          O_RSP0_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cr16_alu_arbiter.sv
// Bench for cr16_alu_arbiter. Instance 0: ALU_LATENCY=1, round-robin.
// Instance 1: ALU_LATENCY=3, fixed priority. A behavioural ALU with matching
// latency sits behind each instance and only presents a correct result on the
// last enabled cycle, so a mistimed capture returns corrupted data.
module tb_cr16_alu_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 4;
  localparam int unsigned SW = 5;

  logic          clk = 1'b0;
  logic          rst_n     [2];
  logic          req_valid [2][2];
  logic          req_ready [2][2];
  logic [OW-1:0] req_op    [2][2];
  logic [DW-1:0] req_a     [2][2];
  logic [DW-1:0] req_b     [2][2];
  logic          rsp_valid [2][2];
  logic          rsp_ready [2][2];
  logic [DW-1:0] rsp_c     [2][2];
  logic [SW-1:0] rsp_st    [2][2];
  logic          alu_en    [2];
  logic [OW-1:0] alu_op    [2];
  logic [DW-1:0] alu_a     [2];
  logic [DW-1:0] alu_b     [2];
  logic [DW-1:0] alu_c     [2];
  logic [SW-1:0] alu_st    [2];
  int            en_cnt    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Reference ALU: returns {status, result}, status = {N, Z, F, L, C}
  function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        f;
    s = '0; c = 1'b0; f = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
        if (op == 4'd0) f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd4: begin
        s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd6:    r = a & b;
      4'd8:    r = a ^ b;
      default: r = (a | ~b) ^ {12'h000, op};
    endcase
    return {r[15], (r == 16'h0000), f, 1'b0, c, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cr16_alu_arbiter #(
      .DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .STATUS_WIDTH(SW),
      .ALU_LATENCY((g == 0) ? 1 : 3), .PRIORITY_MODE((g == 0) ? 0 : 1)
    ) u_dut (
      .I_CLK(clk), .I_NRESET(rst_n[g]),
      .I_REQ0_VALID(req_valid[g][0]), .O_REQ0_READY(req_ready[g][0]),
      .I_REQ0_OPCODE(req_op[g][0]), .I_REQ0_A(req_a[g][0]), .I_REQ0_B(req_b[g][0]),
      .O_RSP0_VALID(rsp_valid[g][0]), .I_RSP0_READY(rsp_ready[g][0]),
      .O_RSP0_C(rsp_c[g][0]), .O_RSP0_STATUS(rsp_st[g][0]),
      .I_REQ1_VALID(req_valid[g][1]), .O_REQ1_READY(req_ready[g][1]),
      .I_REQ1_OPCODE(req_op[g][1]), .I_REQ1_A(req_a[g][1]), .I_REQ1_B(req_b[g][1]),
      .O_RSP1_VALID(rsp_valid[g][1]), .I_RSP1_READY(rsp_ready[g][1]),
      .O_RSP1_C(rsp_c[g][1]), .O_RSP1_STATUS(rsp_st[g][1]),
      .O_ALU_ENABLE(alu_en[g]), .O_ALU_OPCODE(alu_op[g]), .O_ALU_A(alu_a[g]), .O_ALU_B(alu_b[g]),
      .I_ALU_C(alu_c[g]), .I_ALU_STATUS(alu_st[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) en_cnt[k] <= alu_en[k] ? en_cnt[k] + 1 : 0;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      {alu_st[k], alu_c[k]} = (alu_en[k] && (en_cnt[k] == lat_of(k) - 1)) ?
                              alu_f(alu_op[k], alu_a[k], alu_b[k]) : ~alu_f(alu_op[k], alu_a[k], alu_b[k]);
    end
  end

  task automatic reset_inst(input int i);
    rst_n[i] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[i][s] = 1'b0; rsp_ready[i][s] = 1'b0;
      req_op[i][s] = '0; req_a[i][s] = '0; req_b[i][s] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n[i] = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one operation through and reports what was observed (no checking here)
  task automatic do_op(input int i, input int s, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int bp, output int lat, output int en,
                       output bit stable, output bit other, output logic [15:0] c,
                       output logic [4:0] st, output bit to);
    int n;
    lat = 0; en = 0; stable = 1'b1; other = 1'b0; to = 1'b0; c = '0; st = '0;
    req_valid[i][s] = 1'b1; req_op[i][s] = op; req_a[i][s] = a; req_b[i][s] = b;
    #1;
    n = 0;
    while (!req_ready[i][s] && n < 30) begin @(posedge clk); #1; n++; end
    if (!req_ready[i][s]) begin to = 1'b1; req_valid[i][s] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[i][s] = 1'b0;
    lat = 1;
    while (!rsp_valid[i][s] && lat < 30) begin
      if (alu_en[i]) en++;
      if (alu_op[i] !== op || alu_a[i] !== a || alu_b[i] !== b) stable = 1'b0;
      if (rsp_valid[i][1-s]) other = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid[i][s]) begin to = 1'b1; return; end
    c = rsp_c[i][s]; st = rsp_st[i][s];
    repeat (bp) begin
      @(posedge clk); #1;
      if (!rsp_valid[i][s] || rsp_c[i][s] !== c || rsp_st[i][s] !== st || alu_en[i]) stable = 1'b0;
    end
    rsp_ready[i][s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i][s] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) begin
      req_valid[i][s] = 1'b1; req_op[i][s] = 4'd3; req_a[i][s] = 16'h1234; req_b[i][s] = 16'h4321;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (req_ready[i][0] !== 1'b0 || req_ready[i][1] !== 1'b0) begin n_fail++; $display("FAIL reset_ready inst%0d: got %b%b expected 00", i, req_ready[i][1], req_ready[i][0]); end
      n_checks++; if (alu_en[i] !== 1'b0 || alu_a[i] !== 16'h0 || alu_b[i] !== 16'h0 || alu_op[i] !== 4'h0) begin n_fail++; $display("FAIL reset_alu inst%0d: got en=%b a=%h b=%h op=%h expected zeros", i, alu_en[i], alu_a[i], alu_b[i], alu_op[i]); end
      n_checks++; if (rsp_valid[i][0] !== 1'b0 || rsp_valid[i][1] !== 1'b0 || rsp_c[i][0] !== 16'h0 || rsp_st[i][1] !== 5'h0) begin n_fail++; $display("FAIL reset_rsp inst%0d: got v=%b%b c0=%h st1=%h expected zeros", i, rsp_valid[i][1], rsp_valid[i][0], rsp_c[i][0], rsp_st[i][1]); end
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    n_checks++; if (req_ready[0][0] !== 1'b1 || req_ready[0][1] !== 1'b0) begin n_fail++; $display("FAIL reset_rr_start: got ready=%b%b expected 01", req_ready[0][1], req_ready[0][0]); end
    for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) req_valid[i][s] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (alu_en[0] !== 1'b0) begin n_fail++; $display("FAIL reset_no_issue: got en=%b expected 0", alu_en[0]); end
  endtask

  task automatic test_single_op();
    int lat, en; bit stable, other, to; logic [15:0] c; logic [4:0] st;
    reset_inst(0);
    do_op(0, 0, 4'd0, 16'h0005, 16'h0003, 0, lat, en, stable, other, c, st, to);
    n_checks++; if (to || c !== 16'h0008 || st !== 5'h00) begin n_fail++; $display("FAIL add_result: got c=%h st=%h to=%b expected c=0008 st=00", c, st, to); end
    n_checks++; if (lat !== 2 || en !== 1) begin n_fail++; $display("FAIL add_latency: got lat=%0d en=%0d expected 2/1", lat, en); end
    n_checks++; if (!stable || other) begin n_fail++; $display("FAIL add_integrity: got stable=%b rsp1=%b expected 1/0", stable, other); end
  endtask

  task automatic test_both_valid();
    int lat, en; bit stable, other, to; logic [15:0] c; logic [4:0] st;
    reset_inst(0);
    req_valid[0][0] = 1'b1; req_op[0][0] = 4'd4; req_a[0][0] = 16'h0001; req_b[0][0] = 16'h0001;
    req_valid[0][1] = 1'b1; req_op[0][1] = 4'd1; req_a[0][1] = 16'hFFFF; req_b[0][1] = 16'h0001;
    #1;
    n_checks++; if (req_ready[0][0] !== 1'b1 || req_ready[0][1] !== 1'b0) begin n_fail++; $display("FAIL both_first_grant: got ready=%b%b expected 01", req_ready[0][1], req_ready[0][0]); end
    do_op(0, 0, 4'd4, 16'h0001, 16'h0001, 0, lat, en, stable, other, c, st, to);
    n_checks++; if (to || other || c !== 16'h0000 || st[3] !== 1'b1) begin n_fail++; $display("FAIL both_sub: got c=%h st=%h rsp1=%b to=%b expected c=0000 Z=1", c, st, other, to); end
    do_op(0, 1, 4'd1, 16'hFFFF, 16'h0001, 1, lat, en, stable, other, c, st, to);
    n_checks++; if (to || c !== 16'h0000 || st[0] !== 1'b1 || st[3] !== 1'b1) begin n_fail++; $display("FAIL both_addu: got c=%h st=%h to=%b expected c=0000 C=1 Z=1", c, st, to); end
  endtask

  task automatic test_arbitration(input int i);
    int left[2]; int last, exp_g, g, grants, cyc, pend_s; bit pend; logic [20:0] pend_r;
    reset_inst(i);
    left = '{4, 4}; last = 1; pend = 1'b0; pend_s = 0; pend_r = '0; grants = 0; cyc = 0; g = -1;
    rsp_ready[i][0] = 1'b1; rsp_ready[i][1] = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_op[i][s] = 4'($urandom_range(0, 15)); req_a[i][s] = 16'($urandom); req_b[i][s] = 16'($urandom);
    end
    while ((left[0] + left[1] > 0 || pend) && cyc < 200) begin
      for (int s = 0; s < 2; s++) req_valid[i][s] = (left[s] > 0);
      #1;
      for (int s = 0; s < 2; s++) if (rsp_valid[i][s]) begin
        n_checks++; if (!pend || s != pend_s || {rsp_st[i][s], rsp_c[i][s]} !== pend_r) begin n_fail++; $display("FAIL arb%0d_rsp: got side %0d data %h expected side %0d data %h", i, s, {rsp_st[i][s], rsp_c[i][s]}, pend_s, pend_r); end
        pend = 1'b0;
      end
      g = -1;
      if (req_ready[i][0] || req_ready[i][1]) begin
        g = req_ready[i][1] ? 1 : 0;
        if (left[0] > 0 && left[1] > 0) exp_g = (i == 1) ? 0 : 1 - last;
        else exp_g = (left[0] > 0) ? 0 : 1;
        n_checks++; if (g != exp_g || (req_ready[i][0] && req_ready[i][1])) begin n_fail++; $display("FAIL arb%0d_grant%0d: got side %0d (ready=%b%b) expected side %0d", i, grants, g, req_ready[i][1], req_ready[i][0], exp_g); end
        pend = 1'b1; pend_s = g; pend_r = alu_f(req_op[i][g], req_a[i][g], req_b[i][g]);
        left[g]--; last = g; grants++;
      end
      @(posedge clk); #1;
      if (g >= 0) begin
        req_op[i][g] = 4'($urandom_range(0, 15)); req_a[i][g] = 16'($urandom); req_b[i][g] = 16'($urandom);
      end
      cyc++;
    end
    n_checks++; if (grants != 8 || pend) begin n_fail++; $display("FAIL arb%0d_complete: got %0d grants pending=%b expected 8/0", i, grants, pend); end
    for (int s = 0; s < 2; s++) begin req_valid[i][s] = 1'b0; rsp_ready[i][s] = 1'b0; end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b, c; logic [4:0] st; logic [20:0] r; int n;
    reset_inst(0);
    a = 16'($urandom); b = 16'($urandom); r = alu_f(4'd4, a, b);
    req_valid[0][0] = 1'b1; req_op[0][0] = 4'd4; req_a[0][0] = a; req_b[0][0] = b;
    #1; n = 0;
    while (!req_ready[0][0] && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b1; req_op[0][1] = 4'd6; req_a[0][1] = 16'($urandom); req_b[0][1] = 16'($urandom);
    n = 0;
    while (!rsp_valid[0][0] && n < 20) begin @(posedge clk); #1; n++; end
    c = rsp_c[0][0]; st = rsp_st[0][0];
    n_checks++; if ({st, c} !== r) begin n_fail++; $display("FAIL bp_data: got %h expected %h", {st, c}, r); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (rsp_valid[0][0] !== 1'b1 || rsp_c[0][0] !== c || rsp_st[0][0] !== st) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b c=%h st=%h expected 1/%h/%h", k, rsp_valid[0][0], rsp_c[0][0], rsp_st[0][0], c, st); end
      n_checks++; if (req_ready[0][0] !== 1'b0 || req_ready[0][1] !== 1'b0 || alu_en[0] !== 1'b0) begin n_fail++; $display("FAIL bp_quiet%0d: got ready=%b%b en=%b expected 00/0", k, req_ready[0][1], req_ready[0][0], alu_en[0]); end
      @(posedge clk); #1;
    end
    rsp_ready[0][0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0][0] = 1'b0;
    n_checks++; if (rsp_valid[0][0] !== 1'b0 || req_ready[0][1] !== 1'b1) begin n_fail++; $display("FAIL bp_release: got rsp_v=%b ready1=%b expected 0/1", rsp_valid[0][0], req_ready[0][1]); end
    req_valid[0][1] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (alu_en[0] !== 1'b0 || rsp_c[0][1] !== 16'h0000) begin n_fail++; $display("FAIL bp_withdraw: got en=%b c1=%h expected 0/0000", alu_en[0], rsp_c[0][1]); end
  endtask

  task automatic test_reset_mid_exec();
    int lat, en, n, stale; bit stable, other, to; logic [15:0] c; logic [4:0] st;
    reset_inst(1);
    req_valid[1][0] = 1'b1; req_op[1][0] = 4'd0; req_a[1][0] = 16'($urandom); req_b[1][0] = 16'($urandom);
    #1; n = 0;
    while (!req_ready[1][0] && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n_checks++; if (alu_en[1] !== 1'b1) begin n_fail++; $display("FAIL rst_exec_entered: got en=%b expected 1", alu_en[1]); end
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    n_checks++; if (alu_en[1] !== 1'b0 || alu_a[1] !== 16'h0 || alu_b[1] !== 16'h0 || alu_op[1] !== 4'h0) begin n_fail++; $display("FAIL rst_mid_alu: got en=%b a=%h b=%h op=%h expected zeros", alu_en[1], alu_a[1], alu_b[1], alu_op[1]); end
    n_checks++; if (rsp_valid[1][0] !== 1'b0 || rsp_valid[1][1] !== 1'b0 || req_ready[1][0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hs: got rsp_v=%b%b ready0=%b expected 00/0", rsp_valid[1][1], rsp_valid[1][0], req_ready[1][0]); end
    req_valid[1][0] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    stale = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid[1][0] || rsp_valid[1][1]) stale++; end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rst_stale_rsp: got %0d valid cycles expected 0", stale); end
    do_op(1, 0, 4'd6, 16'h00FF, 16'h0F0F, 1, lat, en, stable, other, c, st, to);
    n_checks++; if (to || c !== 16'h000F || st !== 5'h00 || lat != 4) begin n_fail++; $display("FAIL rst_and: got c=%h st=%h lat=%0d to=%b expected 000F/00/4", c, st, lat, to); end
  endtask

  task automatic test_latency3();
    int lat, en; bit stable, other, to; logic [15:0] c; logic [4:0] st;
    do_op(1, 1, 4'd8, 16'hAAAA, 16'hFFFF, 2, lat, en, stable, other, c, st, to);
    n_checks++; if (to || c !== 16'h5555 || st !== 5'h00) begin n_fail++; $display("FAIL lat3_xor: got c=%h st=%h to=%b expected 5555/00", c, st, to); end
    n_checks++; if (en != 3 || lat != 4) begin n_fail++; $display("FAIL lat3_timing: got en=%0d lat=%0d expected 3/4", en, lat); end
    n_checks++; if (!stable || other) begin n_fail++; $display("FAIL lat3_integrity: got stable=%b rsp0=%b expected 1/0", stable, other); end
  endtask

  task automatic test_random();
    int i, s, bp, lat, en; bit stable, other, to; logic [15:0] a, b, c; logic [4:0] st; logic [3:0] op; logic [20:0] r;
    for (int k = 0; k < 16; k++) begin
      i = $urandom_range(0, 1); s = $urandom_range(0, 1); bp = $urandom_range(0, 3);
      op = 4'($urandom_range(0, 15)); a = 16'($urandom); b = 16'($urandom);
      r = alu_f(op, a, b);
      do_op(i, s, op, a, b, bp, lat, en, stable, other, c, st, to);
      n_checks++; if (to || {st, c} !== r) begin n_fail++; $display("FAIL rnd%0d_data: inst%0d side%0d op%0d got %h to=%b expected %h", k, i, s, op, {st, c}, to, r); end
      n_checks++; if (lat != lat_of(i) + 1 || en != lat_of(i)) begin n_fail++; $display("FAIL rnd%0d_timing: got lat=%0d en=%0d expected %0d/%0d", k, lat, en, lat_of(i) + 1, lat_of(i)); end
      n_checks++; if (!stable || other) begin n_fail++; $display("FAIL rnd%0d_integrity: got stable=%b other=%b expected 1/0", k, stable, other); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        req_valid[i][s] = 1'b0; rsp_ready[i][s] = 1'b0;
        req_op[i][s] = '0; req_a[i][s] = '0; req_b[i][s] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_op();
    test_both_valid();
    test_arbitration(0);
    test_arbitration(1);
    test_backpressure();
    test_reset_mid_exec();
    test_latency3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
